// File: rtl/bus_dma_arbiter_pkg.sv
// Shared definitions for the 6510 bus/DMA arbiter: FSM states, bus-owner encoding and
// the pointer-width helper used by the arbiter and its round-robin picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam int OWNER_W = 3;
  localparam logic [OWNER_W-1:0] OWNER_CPU = '0;

  // A single requester still needs a one-bit pointer to keep port widths legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_dma_arbiter_if.sv
// Bus-side signals of the arbiter: DMA requests in, grants and 6510 control lines out.
interface bus_dma_arbiter_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]                     req;
  logic [NREQ-1:0]                     gnt;
  logic                                cpu_rdy;
  logic                                cpu_aec;
  logic                                ph2;
  logic [bus_arb_pkg::OWNER_W-1:0]     bus_owner;
  logic                                busy;

  modport master (
    input  req,
    output gnt, cpu_rdy, cpu_aec, ph2, bus_owner, busy
  );

  modport slave (
    output req,
    input  gnt, cpu_rdy, cpu_aec, ph2, bus_owner, busy
  );

endinterface

// File: rtl/bus_dma_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  logic [NREQ-1:0] rot;
  int              sum;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    gnt_oh_o = '0;
    sum      = 0;
    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    rot      = NREQ'({req_i, req_i} >> ptr_i);
    for (int i = 0; i < NREQ; i++) begin
      if (!valid_o && rot[i]) begin
        valid_o = 1'b1;
        sum     = int'(ptr_i) + i;
        if (sum >= NREQ) sum = sum - NREQ;
        idx_o   = PW'(sum);
      end
    end
    if (valid_o) gnt_oh_o = NREQ'(1) << idx_o;
  end

endmodule

// File: rtl/bus_dma_arbiter.sv
// Shares the 6510 bus with NREQ DMA requesters using the C64-style RDY-then-AEC steal
// sequence, round-robin arbitration and a generated PH2 (one bus cycle = 2 clk).
module bus_dma_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int STEAL_DELAY = 3,
  parameter int MAX_BURST   = 40,
  parameter int CW          = 6
) (
  input  logic               clk,
  input  logic               rst,
  bus_dma_arbiter_if.master  bus
);

  localparam int PW = ptr_width(NREQ);
  localparam logic [CW-1:0] STALL_LOAD = (STEAL_DELAY > 0) ? CW'(STEAL_DELAY - 1) : '0;
  localparam logic [CW-1:0] BURST_LOAD = CW'(MAX_BURST - 1);

  arb_state_e           state_q;
  logic                 ph2_q;
  logic [CW-1:0]        cnt_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        win_idx_q;
  logic [NREQ-1:0]      win_oh_q;
  logic [NREQ-1:0]      gnt_q;
  logic                 rdy_q;
  logic                 aec_q;
  logic [OWNER_W-1:0]   owner_q;
  logic                 busy_q;

  logic [NREQ-1:0]      pick_oh;
  logic [PW-1:0]        pick_idx;
  logic                 pick_vld;
  logic [PW-1:0]        ptr_d;
  logic                 req_win;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .gnt_oh_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_vld)
  );

  function automatic logic [OWNER_W-1:0] owner_of(input logic [PW-1:0] idx);
    return OWNER_W'(idx) + OWNER_W'(1);
  endfunction

  assign ptr_d   = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + PW'(1);
  assign req_win = |(bus.req & win_oh_q);

  // The posedge at which ph2 is high ends the bus cycle; only then does anything but ph2 move.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph2_q     <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      gnt_q     <= '0;
      rdy_q     <= 1'b1;
      aec_q     <= 1'b1;
      owner_q   <= OWNER_CPU;
      busy_q    <= 1'b0;
    end else begin
      ph2_q <= ~ph2_q;
      if (ph2_q) begin
        case (state_q)
          ST_IDLE: begin
            if (pick_vld) begin
              win_idx_q <= pick_idx;
              win_oh_q  <= pick_oh;
              ptr_q     <= ptr_d;
              rdy_q     <= 1'b0;
              busy_q    <= 1'b1;
              if (STEAL_DELAY == 0) begin
                state_q <= ST_GRANT;
                aec_q   <= 1'b0;
                gnt_q   <= pick_oh;
                owner_q <= owner_of(pick_idx);
                cnt_q   <= BURST_LOAD;
              end else begin
                state_q <= ST_STALL;
                cnt_q   <= STALL_LOAD;
              end
            end
          end
          ST_STALL: begin
            // The winner is committed even if its request drops while the CPU drains.
            if (cnt_q == '0) begin
              state_q <= ST_GRANT;
              aec_q   <= 1'b0;
              gnt_q   <= win_oh_q;
              owner_q <= owner_of(win_idx_q);
              cnt_q   <= BURST_LOAD;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_GRANT: begin
            if (!req_win || cnt_q == '0) begin
              state_q <= ST_RELEASE;
              gnt_q   <= '0;
              aec_q   <= 1'b1;
              owner_q <= OWNER_CPU;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_RELEASE: begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.cpu_rdy   = rdy_q;
  assign bus.cpu_aec   = aec_q;
  assign bus.ph2       = ph2_q;
  assign bus.bus_owner = owner_q;
  assign bus.busy      = busy_q;

endmodule
